imem_loader: RTL

Boot-time program loader for the femtoRV32 core. It receives a length-prefixed, checksummed byte stream over a valid/ready interface and assembles little-endian 32-bit words. It writes those words sequentially into instruction memory starting at word 0, and holds the CPU in reset until a load completes cleanly. It is the write side of the instruction memory that the fetch stage reads, and replaces the static MEMFILE image when programs are downloaded at run time.

---
 rtl/imem_loader.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that turns a length-prefixed, XOR-checksummed byte
// stream into sequential little-endian 32-bit instruction-memory writes.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    ST_LEN_LO = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_DATA   = 3'd2,
    ST_CSUM   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  // One more bit than the address so a full-capacity word count is representable.
  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

  state_t      state_r;
  state_t      state_s;
  logic [15:0] len_r;
  logic [1:0]  byte_cnt_r;
  logic [23:0] hold_r;
  logic [16:0] word_idx_r;
  logic [7:0]  csum_r;

  logic        loading_s;
  logic        accept_s;
  logic        restart_s;
  logic        last_word_s;
  logic [15:0] len_full_s;

  // Handshake and shared decode used by both the FSM and the datapath.
  always_comb begin
    loading_s = 1'b0;
    case (state_r)
      ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM: loading_s = 1'b1;
      default:                                loading_s = 1'b0;
    endcase
    rx_ready    = loading_s & ~rst;
    accept_s    = rx_valid & rx_ready;
    restart_s   = ~loading_s & reload;
    len_full_s  = {rx_data, len_r[7:0]};
    last_word_s = ((word_idx_r + 17'd1) == {1'b0, len_r});
  end

  // Status outputs decode straight from the state register.
  always_comb begin
    done    = 1'b0;
    err     = 1'b0;
    cpu_rst = 1'b1;
    case (state_r)
      ST_DONE: begin
        done    = 1'b1;
        cpu_rst = 1'b0;
      end
      ST_ERROR: err = 1'b1;
      default: begin
        done    = 1'b0;
        err     = 1'b0;
        cpu_rst = 1'b1;
      end
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_LEN_LO: begin
        if (accept_s) state_s = ST_LEN_HI;
        else          state_s = state_r;
      end
      ST_LEN_HI: begin
        if (!accept_s)                             state_s = state_r;
        else if ({1'b0, len_full_s} > CAPACITY)    state_s = ST_ERROR;
        else if (len_full_s == 16'd0)              state_s = ST_CSUM;
        else                                       state_s = ST_DATA;
      end
      ST_DATA: begin
        if (accept_s && (byte_cnt_r == 2'd3) && last_word_s) state_s = ST_CSUM;
        else                                                 state_s = state_r;
      end
      ST_CSUM: begin
        if (!accept_s)              state_s = state_r;
        else if (rx_data == csum_r) state_s = ST_DONE;
        else                        state_s = ST_ERROR;
      end
      ST_DONE, ST_ERROR: begin
        if (reload) state_s = ST_LEN_LO;
        else        state_s = state_r;
      end
      default: state_s = ST_LEN_LO;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_LEN_LO;
    else     state_r <= state_s;
  end

  // Length capture, word assembly, checksum accumulation and memory write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_r      <= 16'd0;
      byte_cnt_r <= 2'd0;
      hold_r     <= 24'd0;
      word_idx_r <= 17'd0;
      csum_r     <= 8'd0;
      mem_we     <= 1'b0;
      mem_addr   <= {ADDR_W{1'b0}};
      mem_wdata  <= 32'd0;
    end else begin
      mem_we <= 1'b0;
      if (restart_s) begin
        byte_cnt_r <= 2'd0;
        word_idx_r <= 17'd0;
        csum_r     <= 8'd0;
      end else if (accept_s) begin
        case (state_r)
          ST_LEN_LO: len_r[7:0]  <= rx_data;
          ST_LEN_HI: len_r[15:8] <= rx_data;
          ST_DATA: begin
            csum_r     <= csum_r ^ rx_data;
            byte_cnt_r <= byte_cnt_r + 2'd1;
            // Earlier bytes sit in the low positions; the 4th byte completes [31:24].
            if (byte_cnt_r == 2'd3) begin
              mem_we     <= 1'b1;
              mem_addr   <= word_idx_r[ADDR_W-1:0];
              mem_wdata  <= {rx_data, hold_r};
              word_idx_r <= word_idx_r + 17'd1;
            end else begin
              hold_r <= {rx_data, hold_r[23:8]};
            end
          end
          default: begin
            len_r <= len_r;
          end
        endcase
      end else begin
        len_r <= len_r;
      end
    end
  end

endmodule
